// File: rtl/keccak_padder.sv
// -----------------------------------------------------------------------------
// keccak_padder
//
// Message padder for Keccak-512, feeding the Keccak-f[1600] permutation.
// 64-bit message words are shifted into an R-bit rate block, oldest word at
// the top. After the final (possibly partial) word the padder appends the
// multi-rate padding 0x01 ... 0x80, emitting zero words on its own until the
// block is full. A full block is held on `out` until the permutation
// acknowledges it with f_ack. Once the block carrying the final padding has
// been acknowledged, the padder stays busy until reset.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low; clears all state
//   in           in   64  message word, byte 0 = in[63:56]
//   in_ready     in   1   in / is_last / byte_num valid this cycle
//   is_last      in   1   this is the final word of the message
//   byte_num     in   3   valid bytes in the final word (0..7)
//   buffer_full  out  1   padder cannot take a word (block held, padding, done)
//   out          out  R   assembled rate block, word 0 at out[R-1:R-64]
//   out_ready    out  1   out holds a complete block
//   f_ack        in   1   permutation consumed out this cycle
// -----------------------------------------------------------------------------
module keccak_padder #(
    parameter int R = 576
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [63:0]  in,
    input  logic         in_ready,
    input  logic         is_last,
    input  logic [2:0]   byte_num,
    output logic         buffer_full,
    output logic [R-1:0] out,
    output logic         out_ready,
    input  logic         f_ack
);

    localparam int W  = R / 64;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pad_q, pad_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic [R-1:0]  out_q, out_d;
    logic          out_ready_q, out_ready_d;
    logic          buffer_full_q, buffer_full_d;

    logic          block_full;
    logic          at_block_end;
    logic [63:0]   last_word;
    logic [63:0]   in_word;
    logic [63:0]   pad_word;
    logic [63:0]   shift_word;
    logic [R-1:0]  shifted;

    assign block_full   = (cnt_q == CNT_FULL);
    // The word about to enter is the last slot of the block.
    assign at_block_end = (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Final-word formatting: keep the first byte_num bytes, place the 0x01
    // domain/padding byte right after them, zero the remainder.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_last_byte
        localparam logic [2:0] IDX = 3'(gi);
        assign last_word[63-8*gi -: 8] = (IDX < byte_num)  ? in[63-8*gi -: 8] :
                                         (IDX == byte_num) ? 8'h01 : 8'h00;
    end

    // When the final word also closes the block, the trailing 0x80 lands in
    // the same word (byte_num = 7 yields 0x81 in the low byte).
    assign in_word    = is_last ? (last_word | {56'd0, (at_block_end ? 8'h80 : 8'h00)})
                                : in;
    assign pad_word   = at_block_end ? 64'h0000_0000_0000_0080 : 64'd0;
    assign shift_word = pad_q ? pad_word : in_word;

    // Shift a new word in at the bottom; a single-word rate has nothing to keep.
    if (W > 1) begin : g_shift
        assign shifted = {out_q[R-65:0], shift_word};
    end else begin : g_noshift
        assign shifted = shift_word;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        pad_d  = pad_q;
        last_d = last_q;
        done_d = done_q;
        out_d  = out_q;

        if (block_full) begin
            // Holding a complete block: only an acknowledge moves us on.
            if (f_ack) begin
                cnt_d = '0;
                if (last_q) begin
                    done_d = 1'b1;
                end
            end
        end else if (pad_q) begin
            // Self-generated padding word, no input consumed.
            out_d = shifted;
            cnt_d = cnt_q + CW'(1);
            if (at_block_end) begin
                pad_d = 1'b0;
            end
        end else if (in_ready && !buffer_full_q && !done_q) begin
            out_d = shifted;
            cnt_d = cnt_q + CW'(1);
            if (is_last) begin
                last_d = 1'b1;
                if (!at_block_end) begin
                    pad_d = 1'b1;
                end
            end
        end

        // Status outputs are registered copies of the next state so that
        // neither f_ack nor in_ready reaches them combinationally.
        out_ready_d   = (cnt_d == CNT_FULL);
        buffer_full_d = (cnt_d == CNT_FULL) | pad_d | done_d;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            pad_q         <= 1'b0;
            last_q        <= 1'b0;
            done_q        <= 1'b0;
            out_q         <= '0;
            out_ready_q   <= 1'b0;
            buffer_full_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            pad_q         <= pad_d;
            last_q        <= last_d;
            done_q        <= done_d;
            out_q         <= out_d;
            out_ready_q   <= out_ready_d;
            buffer_full_q <= buffer_full_d;
        end
    end

    assign out         = out_q;
    assign out_ready   = out_ready_q;
    assign buffer_full = buffer_full_q;

endmodule
